// File: rtl/button_pulse_gen_if.sv
// rtl/button_pulse_gen_if.sv - raw button inputs and pulse outputs of button_pulse_gen
//
// Purpose: bundles the two raw push-buttons and the three strobes that
// button_pulse_gen produces, so the block and its user share one bundle.
// Signals:
//   i_btn_inc    raw increment button, asynchronous to the clock
//   i_btn_dec    raw decrement button, asynchronous to the clock
//   o_inc_pulse  one-clock increment strobe
//   o_dec_pulse  one-clock decrement strobe
//   o_tick       one-clock millisecond strobe
// Modports: master drives the buttons and observes the strobes; slave is
// the conditioner itself.

interface button_pulse_gen_if;
  logic i_btn_inc;
  logic i_btn_dec;
  logic o_inc_pulse;
  logic o_dec_pulse;
  logic o_tick;

  modport master (
    output i_btn_inc,
    output i_btn_dec,
    input  o_inc_pulse,
    input  o_dec_pulse,
    input  o_tick
  );

  modport slave (
    input  i_btn_inc,
    input  i_btn_dec,
    output o_inc_pulse,
    output o_dec_pulse,
    output o_tick
  );
endinterface

// File: rtl/button_pulse_gen.sv
// rtl/button_pulse_gen.sv - debounced inc/dec push-button pulse generator with auto-repeat
//
// Purpose: synchronises and debounces the two clock-setting buttons and
// turns each press into one-clock pulses, repeating slowly and then fast
// while a button stays held. Pressing both buttons locks both outputs off
// until both are released.
// Ports:
//   i_clk      system clock, all logic on the rising edge
//   i_reset_n  asynchronous active-low reset
//   bus        slave side of button_pulse_gen_if (raw buttons in,
//              o_inc_pulse / o_dec_pulse / o_tick out)

module button_pulse_gen #(
  parameter int CLK_DIV         = 100000,
  parameter int DEBOUNCE_MS     = 20,
  parameter int REPEAT_DELAY_MS = 500,
  parameter int REPEAT_MS       = 100,
  parameter int FAST_AFTER      = 10,
  parameter int REPEAT_FAST_MS  = 25,
  parameter int BTN_ACTIVE_LOW  = 1
) (
  input logic               i_clk,
  input logic               i_reset_n,
  button_pulse_gen_if.slave bus
);

  localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PW-1:0] PS_LAST = PW'(CLK_DIV - 1);
  localparam logic [PW-1:0] PS_ONE  = PW'(1);

  localparam int DW = $clog2(DEBOUNCE_MS + 1);
  localparam logic [DW-1:0] DB_LIM = DW'(DEBOUNCE_MS);
  localparam logic [DW-1:0] DB_ONE = DW'(1);

  localparam int HMAX0 = (REPEAT_DELAY_MS > REPEAT_MS) ? REPEAT_DELAY_MS : REPEAT_MS;
  localparam int HMAX  = (HMAX0 > REPEAT_FAST_MS) ? HMAX0 : REPEAT_FAST_MS;
  localparam int HW    = $clog2(HMAX + 1);
  localparam logic [HW-1:0] HOLD_LIM = HW'(REPEAT_DELAY_MS);
  localparam logic [HW-1:0] SLOW_LIM = HW'(REPEAT_MS);
  localparam logic [HW-1:0] FAST_LIM = HW'(REPEAT_FAST_MS);
  localparam logic [HW-1:0] HOLD_ONE = HW'(1);

  localparam int RW = $clog2(FAST_AFTER + 1);
  localparam logic [RW-1:0] RPT_SAT = RW'(FAST_AFTER);
  localparam logic [RW-1:0] RPT_ONE = RW'(1);

  // Raw level of a released button; synchronisers reset to it so a button
  // held through reset is seen as a fresh press afterwards.
  localparam logic REL = (BTN_ACTIVE_LOW != 0);

  typedef enum logic [1:0] {IDLE, HOLD, REPEAT} state_t;

  // Index 0 is the increment button, index 1 the decrement button.
  logic [1:0]    sync1_q, sync2_q, pressed;
  logic [PW-1:0] ps_q;
  logic          tick;
  logic [1:0]    db_q, db_d;
  logic [DW-1:0] dbc_q [2];
  logic [DW-1:0] dbc_d [2];
  logic          lock_q, lock_d;
  state_t        state_q [2];
  state_t        state_d [2];
  logic [HW-1:0] hold_q [2];
  logic [HW-1:0] hold_d [2];
  logic [HW-1:0] ival [2];
  logic [RW-1:0] rpt_q [2];
  logic [RW-1:0] rpt_d [2];
  logic [1:0]    pulse_d, pulse_q;

  assign pressed = sync2_q ^ {2{REL}};
  assign tick    = (ps_q == PS_LAST);

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      sync1_q <= {2{REL}};
      sync2_q <= {2{REL}};
      ps_q    <= '0;
      db_q    <= '0;
      lock_q  <= 1'b0;
      pulse_q <= '0;
      for (int b = 0; b < 2; b++) begin
        dbc_q[b]   <= '0;
        state_q[b] <= IDLE;
        hold_q[b]  <= '0;
        rpt_q[b]   <= '0;
      end
    end else begin
      sync1_q <= {bus.i_btn_dec, bus.i_btn_inc};
      sync2_q <= sync1_q;
      ps_q    <= tick ? '0 : ps_q + PS_ONE;
      db_q    <= db_d;
      lock_q  <= lock_d;
      pulse_q <= pulse_d;
      for (int b = 0; b < 2; b++) begin
        dbc_q[b]   <= dbc_d[b];
        state_q[b] <= state_d[b];
        hold_q[b]  <= hold_d[b];
        rpt_q[b]   <= rpt_d[b];
      end
    end
  end

  // Debounce: a differing level must persist across DEBOUNCE_MS ticks.
  always_comb begin
    db_d = db_q;
    for (int b = 0; b < 2; b++) begin
      dbc_d[b] = dbc_q[b];
      if (pressed[b] == db_q[b]) begin
        dbc_d[b] = '0;
      end else if (tick) begin
        if (dbc_q[b] + DB_ONE == DB_LIM) begin
          db_d[b]  = ~db_q[b];
          dbc_d[b] = '0;
        end else begin
          dbc_d[b] = dbc_q[b] + DB_ONE;
        end
      end
    end
    // Decided on the new debounced levels so that a press edge arriving in
    // the very cycle both become pressed is already suppressed.
    lock_d = lock_q ? (db_d != 2'b00) : (db_d == 2'b11);
  end

  always_comb begin
    pulse_d = '0;
    for (int b = 0; b < 2; b++) begin
      state_d[b] = state_q[b];
      hold_d[b]  = hold_q[b];
      rpt_d[b]   = rpt_q[b];
      ival[b]    = (rpt_q[b] < RPT_SAT) ? SLOW_LIM : FAST_LIM;
      if (lock_d) begin
        state_d[b] = IDLE;
        hold_d[b]  = '0;
        rpt_d[b]   = '0;
      end else begin
        case (state_q[b])
          IDLE: begin
            if (db_d[b] && !db_q[b]) begin
              pulse_d[b] = 1'b1;
              hold_d[b]  = '0;
              rpt_d[b]   = '0;
              state_d[b] = HOLD;
            end
          end
          HOLD: begin
            if (!db_d[b]) begin
              state_d[b] = IDLE;
            end else if (tick) begin
              if (hold_q[b] + HOLD_ONE == HOLD_LIM) begin
                pulse_d[b] = 1'b1;
                rpt_d[b]   = RPT_ONE;
                hold_d[b]  = '0;
                state_d[b] = REPEAT;
              end else begin
                hold_d[b] = hold_q[b] + HOLD_ONE;
              end
            end
          end
          REPEAT: begin
            if (!db_d[b]) begin
              state_d[b] = IDLE;
            end else if (tick) begin
              if (hold_q[b] + HOLD_ONE == ival[b]) begin
                pulse_d[b] = 1'b1;
                hold_d[b]  = '0;
                if (rpt_q[b] < RPT_SAT) begin
                  rpt_d[b] = rpt_q[b] + RPT_ONE;
                end
              end else begin
                hold_d[b] = hold_q[b] + HOLD_ONE;
              end
            end
          end
          default: state_d[b] = IDLE;
        endcase
      end
    end
  end

  assign bus.o_inc_pulse = pulse_q[0];
  assign bus.o_dec_pulse = pulse_q[1];
  assign bus.o_tick      = tick;

endmodule

// File: tb/tb_button_pulse_gen.sv
// tb/tb_button_pulse_gen.sv - self-checking bench for button_pulse_gen
//
// Purpose: drives directed and random button activity into button_pulse_gen
// and compares every output, every cycle, against a behavioural model that
// places pulses on a tick schedule computed from cumulative offsets.
// Ports: none.

module tb_button_pulse_gen;
  localparam int C  = 4;
  localparam int D  = 3;
  localparam int RD = 10;
  localparam int RS = 4;
  localparam int FA = 2;
  localparam int RF = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   inc_t[$];
  int   dec_t[$];
  int   tick_t[$];
  bit   prev_any = 1'b0;

  button_pulse_gen_if bus();

  button_pulse_gen #(
    .CLK_DIV(C), .DEBOUNCE_MS(D), .REPEAT_DELAY_MS(RD), .REPEAT_MS(RS),
    .FAST_AFTER(FA), .REPEAT_FAST_MS(RF), .BTN_ACTIVE_LOW(1)
  ) dut (
    .i_clk(clk),
    .i_reset_n(rst_n),
    .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [1:0] m_raw[$];
  int m_cyc;
  bit m_lev[2];
  int m_stab[2];
  bit m_lock;
  bit m_act[2];
  int m_since[2];
  bit exp_inc  = 1'b0;
  bit exp_dec  = 1'b0;
  bit exp_tick = 1'b0;

  // Pulse offsets in ticks after the press: 0, RD, then RS gaps until FA
  // repeats have been emitted, RF gaps after that.
  function automatic bit on_schedule(input int n);
    int t;
    int k;
    if (n == 0) return 1'b1;
    t = RD;
    k = 1;
    while (t < n) begin
      t += (k < FA) ? RS : RF;
      k++;
    end
    return t == n;
  endfunction

  task automatic model_reset();
    m_raw.delete();
    m_raw.push_back(2'b11);
    m_raw.push_back(2'b11);
    m_cyc = 0;
    m_lock = 1'b0;
    for (int b = 0; b < 2; b++) begin
      m_lev[b] = 1'b0; m_stab[b] = 0; m_act[b] = 1'b0; m_since[b] = 0;
    end
    exp_inc = 1'b0; exp_dec = 1'b0; exp_tick = 1'b0;
  endtask

  task automatic model_step();
    bit tick_now;
    logic [1:0] syn;
    bit old_lev[2];
    bit pul[2];
    tick_now = (m_cyc % C) == C - 1;
    syn = m_raw.pop_front();
    m_raw.push_back({bus.i_btn_dec, bus.i_btn_inc});
    for (int b = 0; b < 2; b++) begin
      old_lev[b] = m_lev[b];
      pul[b] = 1'b0;
      if ((syn[b] == 1'b0) == m_lev[b]) m_stab[b] = 0;
      else if (tick_now) begin
        m_stab[b]++;
        if (m_stab[b] == D) begin
          m_lev[b] = !m_lev[b];
          m_stab[b] = 0;
        end
      end
    end
    if (m_lock) m_lock = m_lev[0] || m_lev[1];
    else        m_lock = m_lev[0] && m_lev[1];
    for (int b = 0; b < 2; b++) begin
      if (m_lock || !m_lev[b]) m_act[b] = 1'b0;
      else if (!old_lev[b]) begin
        m_act[b] = 1'b1; m_since[b] = 0; pul[b] = 1'b1;
      end else if (m_act[b] && tick_now) begin
        m_since[b]++;
        pul[b] = on_schedule(m_since[b]);
      end
    end
    exp_inc = pul[0];
    exp_dec = pul[1];
    m_cyc++;
    exp_tick = (m_cyc % C) == C - 1;
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) model_reset();
    else        model_step();
  end

  always @(negedge clk) begin
    check("inc_pulse", bus.o_inc_pulse, exp_inc);
    check("dec_pulse", bus.o_dec_pulse, exp_dec);
    check("tick", bus.o_tick, exp_tick);
    if (bus.o_inc_pulse) inc_t.push_back(cyc);
    if (bus.o_dec_pulse) dec_t.push_back(cyc);
    if (bus.o_tick) tick_t.push_back(cyc);
    if (bus.o_inc_pulse || bus.o_dec_pulse) begin
      check("pulse_exclusive", bus.o_inc_pulse & bus.o_dec_pulse, 0);
      check("pulse_spacing", prev_any, 0);
    end
    prev_any <= bus.o_inc_pulse || bus.o_dec_pulse;
  end

  // ---------------- stimulus ----------------
  task automatic clocks(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic set_btn(input bit inc_p, input bit dec_p);
    bus.i_btn_inc = !inc_p;
    bus.i_btn_dec = !dec_p;
  endtask

  task automatic clear_log();
    inc_t.delete();
    dec_t.delete();
    tick_t.delete();
  endtask

  task automatic wait_count(input string tag, input int which, input int target, input int budget);
    int n = 0;
    while (((which == 0) ? inc_t.size() : dec_t.size()) < target && n < budget) begin
      clocks(1);
      n++;
    end
    check(tag, (which == 0) ? inc_t.size() : dec_t.size(), target);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int r;
    int t;
    int n0;
    int exp_off[6] = '{0, 40, 56, 64, 72, 80};

    // Reset with the increment button already held.
    set_btn(1, 0);
    rst_n = 1'b0;
    clocks(3);
    check("rst_inc_zero", bus.o_inc_pulse, 0);
    check("rst_dec_zero", bus.o_dec_pulse, 0);
    check("rst_tick_zero", bus.o_tick, 0);
    clear_log();
    rst_n = 1'b1;
    r = cyc;
    wait_count("rst_first_pulse", 0, 1, 30);
    if (inc_t.size() > 0)
      check("rst_latency_11_15", (inc_t[0] - r >= 11) && (inc_t[0] - r <= 15), 1);
    if (tick_t.size() >= 3) begin
      check("tick_first", tick_t[0] - r, 3);
      check("tick_period_a", tick_t[1] - tick_t[0], 4);
      check("tick_period_b", tick_t[2] - tick_t[1], 4);
    end else check("tick_seen", tick_t.size(), 3);
    clocks(15);
    check("rst_single_pulse", inc_t.size(), 1);
    set_btn(0, 0);
    clocks(30);

    // Bouncing decrement line, then a clean hold.
    clear_log();
    for (int i = 0; i < 10; i++) begin
      bus.i_btn_dec = ~bus.i_btn_dec;
      clocks(3);
    end
    bus.i_btn_dec = 1'b0;
    t = cyc;
    clocks(20);
    set_btn(0, 0);
    clocks(30);
    check("bounce_count", dec_t.size(), 1);
    check("bounce_no_inc", inc_t.size(), 0);
    // clocks from the settling edge through the pulse cycle
    if (dec_t.size() > 0) check("bounce_settle", (dec_t[0] - t + 1) >= 12, 1);

    // Auto-repeat while held.
    clear_log();
    set_btn(1, 0);
    wait_count("rep_first", 0, 1, 30);
    clocks(88);
    set_btn(0, 0);
    clocks(40);
    if (inc_t.size() >= 6) begin
      for (int i = 0; i < 6; i++)
        check($sformatf("rep_offset%0d", i), inc_t[i] - inc_t[0], exp_off[i]);
    end else check("rep_count", inc_t.size(), 6);
    n0 = inc_t.size();
    clocks(60);
    check("rep_quiet_after_release", inc_t.size(), n0);
    check("rep_no_dec", dec_t.size(), 0);

    // Both pressed on the same clock.
    clear_log();
    set_btn(1, 1);
    clocks(100);
    check("simul_no_inc", inc_t.size(), 0);
    check("simul_no_dec", dec_t.size(), 0);
    set_btn(0, 0);
    clocks(30);
    set_btn(0, 1);
    clocks(25);
    set_btn(0, 0);
    clocks(30);
    check("simul_then_dec", dec_t.size(), 1);
    check("simul_then_no_inc", inc_t.size(), 0);

    // Second button pressed while the first is held.
    clear_log();
    set_btn(1, 0);
    wait_count("lock_first", 0, 1, 30);
    clocks(20);
    set_btn(1, 1);
    clocks(80);
    check("lock_no_dec", dec_t.size(), 0);
    check("lock_no_inc_repeat", inc_t.size(), 1);
    set_btn(0, 0);
    clocks(30);

    // Reset while repeating, button kept held through it.
    clear_log();
    set_btn(1, 0);
    wait_count("rmr_three_pulses", 0, 3, 120);
    clocks(7);
    check("rmr_pulse_before_reset", bus.o_inc_pulse, 1);
    rst_n = 1'b0;
    #1;
    check("rmr_inc_zero", bus.o_inc_pulse, 0);
    check("rmr_dec_zero", bus.o_dec_pulse, 0);
    check("rmr_tick_zero", bus.o_tick, 0);
    clocks(2);
    clear_log();
    rst_n = 1'b1;
    wait_count("rmr_fresh_two", 0, 2, 100);
    if (inc_t.size() >= 2) check("rmr_restart_gap", inc_t[1] - inc_t[0], 40);
    set_btn(0, 0);
    clocks(30);

    // Random activity with occasional resets; the model checks every cycle.
    for (int i = 0; i < 60; i++) begin
      set_btn(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 15) == 0) begin
        rst_n = 1'b0;
        clocks($urandom_range(1, 3));
        rst_n = 1'b1;
      end
      clocks($urandom_range(1, 70));
    end
    set_btn(0, 0);
    clocks(30);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/button_pulse_gen.md
# button_pulse_gen

Front-end conditioner for the two clock-setting push-buttons. Synchronises and debounces the raw inc/dec buttons and turns each press into single-cycle `inc`/`dec` pulses, with auto-repeat (slow, then fast) while a button is held. Sits directly upstream of `clock_control`: `o_inc_pulse`/`o_dec_pulse` drive its `i_inc_pulse`/`i_dec_pulse`. It contains its own millisecond prescaler, so it needs no external tick.

## Interface
- `CLK_DIV`, 100000: clocks per internal ms tick (100 MHz → 1 ms).
- `DEBOUNCE_MS`, 20: consecutive ticks a changed level must hold before it is accepted.
- `REPEAT_DELAY_MS`, 500: ticks of hold before the first auto-repeat pulse.
- `REPEAT_MS`, 100: slow repeat interval, in ticks.
- `FAST_AFTER`, 10: number of repeat pulses before switching to the fast interval.
- `REPEAT_FAST_MS`, 25: fast repeat interval, in ticks.
- `BTN_ACTIVE_LOW`, 1: raw button polarity (1 = pressed reads 0).
- `i_clk`  in  1  single system clock; all logic on rising edge.
- `i_reset_n`  in  1  reset, asynchronous assert, active-low.
- `i_btn_inc`  in  1  raw increment button, asynchronous to `i_clk`.
- `i_btn_dec`  in  1  raw decrement button, asynchronous to `i_clk`.
- `o_inc_pulse`  out  1  one-clock increment strobe.
- `o_dec_pulse`  out  1  one-clock decrement strobe.
- `o_tick`  out  1  one-clock ms strobe, exported for reuse.

## Operation
- **Reset:**
  - all counters are 0; every output is 0.
  - Synchroniser flops load the *released* level, so they hold `BTN_ACTIVE_LOW` at reset.
  - Debounced states are released; both button FSMs are in `IDLE`; the lockout flag is clear.
- **Synchroniser:** 2-flop per button. Polarity is normalised after sync, so that internally 1 means pressed.
- **Prescaler:**
  - counts 0..`CLK_DIV`-1 and wraps.
  - `o_tick`=1 in the cycle the count equals `CLK_DIV`-1.
  - Free-running; it is never reset by button activity.
- **Debouncer (per button):**
  - The stable counter clears in any cycle where the synced level equals the debounced level.
  - On each tick where they differ, the counter increments.
  - When the incremented value reaches `DEBOUNCE_MS`, the debounced level flips and the counter clears.
- **Per-button FSM, press path:**
  - `IDLE`: on a debounced press edge, emit one pulse, clear the hold and repeat counters, and go to `HOLD`.
  - `HOLD`: count ticks. When the count reaches `REPEAT_DELAY_MS`, emit a pulse, set repeat count = 1, clear the hold counter, and go to `REPEAT`.
- **Per-button FSM, repeat path:**
  - `REPEAT`: the interval is `REPEAT_MS` while repeat count < `FAST_AFTER`, else `REPEAT_FAST_MS`.
  - When the interval is reached, emit a pulse, clear the hold counter, and increment the repeat count, saturating at `FAST_AFTER`.
  - From `HOLD` or `REPEAT`, a debounced release returns the FSM to `IDLE` the same cycle, with no pulse.
- **Lockout:**
  - Entered when both debounced levels are pressed in the same cycle.
  - While set, both FSMs are forced to `IDLE` and both outputs are held at 0.
  - Cleared only when both debounced levels are released.
  - A press edge arriving in the cycle lockout is entered produces no pulse. This covers simultaneous edges and a second button pressed while the first is held.
- **Pulse rules:**
  - `o_inc_pulse` and `o_dec_pulse` are never high together.
  - Each pulse is exactly 1 clock wide, and pulses never occur on consecutive cycles.

## Timing
- Outputs are registered. A pulse appears in the cycle after the triggering tick or debounced edge is registered.
- Raw press to first pulse:
  - 2 sync cycles, plus (`DEBOUNCE_MS`-1)×`CLK_DIV` to `DEBOUNCE_MS`×`CLK_DIV` cycles depending on prescaler phase, plus 1 output register cycle.
- Repeat pulses are spaced by exactly an interval × `CLK_DIV` clocks, because every pulse is aligned to a tick.
- Asynchronous reset mid-hold:
  - outputs go to 0 immediately.
  - A button still held after reset is seen as a fresh press and gives one pulse after debounce.

## Test plan
Common parameters for all scenarios: `CLK_DIV`=4, `DEBOUNCE_MS`=3, `REPEAT_DELAY_MS`=10, `REPEAT_MS`=4, `FAST_AFTER`=2, `REPEAT_FAST_MS`=2, `BTN_ACTIVE_LOW`=1.

- **Reset:** hold `i_reset_n`=0 with `i_btn_inc`=0 → all outputs 0. Release reset with the button still held → exactly one `o_inc_pulse` 11–15 clocks after the synchroniser sees the press. `o_tick` then recurs every 4 clocks.
- **Bounce:** toggle `i_btn_dec` every 3 clocks for 30 clocks, then hold it low for 20 clocks, then release → exactly one `o_dec_pulse`, arriving after the line has been stable for at least 12 clocks.
- **Auto-repeat:** hold inc for 90 clocks after its first pulse → 6 `o_inc_pulse`, at 0, 40, 56, 64, 72 and 80 clocks after the first. Release → no further pulses.
- **Simultaneous press:** press inc and dec on the same clock and hold both for 100 clocks → zero pulses on both outputs. Release both, then press dec alone → normal single `o_dec_pulse`.
- **Second-button lockout:** hold inc, then press dec 20 clocks after the first `o_inc_pulse` → no `o_dec_pulse`, and no further `o_inc_pulse` until both buttons are released.
- **Reset mid-repeat:** assert `i_reset_n`=0 during the `REPEAT` state → outputs 0 the same cycle, FSMs return to `IDLE`, and the repeat count restarts from 0 on the next hold.
